// File: rtl/sram_chan_req.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_chan_req                                                   |
// | Purpose  : Channel-side initiator for the daisy-chained SRAM bank array.   |
// |            Takes read/write requests from one client over valid/ready,     |
// |            drives them as single-cycle registered commands onto this       |
// |            channel's lane, captures read data RD_LATENCY cycles after the  |
// |            command and returns it in order through a credit-protected      |
// |            response FIFO.                                                  |
// | Option   : `define SRAM_CHAN_REQ_WR_ACK_EN makes writes consume a credit   |
// |            and return a completion (rsp_data = 0, rsp_id echoed).          |
// | Ports    : clk, rst_n         clock, asynchronous active-low reset         |
// |            req_vld/req_rdy    request handshake                           |
// |            req_wr/addr/data/id request payload                            |
// |            wr_cmd_vld, rd_cmd_vld, addr, wr_cmd_data  lane command         |
// |            rd_data_in         read data returned on the lane              |
// |            rsp_vld/rsp_rdy    response handshake                          |
// |            rsp_data, rsp_id   response payload (FIFO head)                |
// |            outstanding        credits in use                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sram_chan_req #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int RD_LATENCY = 2,   // legal range 1..8
   parameter int RSP_DEPTH  = 4    // power of two, >= 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   // client request
   input  logic                        req_vld,
   output logic                        req_rdy,
   input  logic                        req_wr,
   input  logic [ADDR_WIDTH-1:0]       req_addr,
   input  logic [DATA_WIDTH-1:0]       req_data,
   input  logic [ID_WIDTH-1:0]         req_id,
   // chain lane
   output logic                        wr_cmd_vld,
   output logic                        rd_cmd_vld,
   output logic [ADDR_WIDTH-1:0]       addr,
   output logic [DATA_WIDTH-1:0]       wr_cmd_data,
   input  logic [DATA_WIDTH-1:0]       rd_data_in,
   // client response
   output logic                        rsp_vld,
   input  logic                        rsp_rdy,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic [ID_WIDTH-1:0]         rsp_id,
   output logic [$clog2(RSP_DEPTH):0]  outstanding
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RSP_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

   // ------------------------------------------------------------------------
   // Request acceptance and credit accounting
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] r_credits;
   logic             w_accept;
   logic             w_acc_rd;
   logic             w_acc_wr;
   logic             w_take_credit;
   logic             w_pop;
   logic             w_push;

   // One rule for every request type: no credit, no accept.
   assign req_rdy  = (r_credits != '0);
   assign w_accept = req_vld & req_rdy;
   assign w_acc_wr = w_accept & req_wr;
   assign w_acc_rd = w_accept & ~req_wr;

`ifdef SRAM_CHAN_REQ_WR_ACK_EN
   assign w_take_credit = w_accept;
`else
   assign w_take_credit = w_acc_rd;
`endif

   // A credit is reserved at accept time and returned only when the response
   // leaves the FIFO, so the FIFO can never be pushed while full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= DEPTH_C;
      end else if (w_take_credit && !w_pop) begin
         r_credits <= r_credits - CNT_ONE_C;
      end else if (!w_take_credit && w_pop) begin
         r_credits <= r_credits + CNT_ONE_C;
      end
   end

   assign outstanding = DEPTH_C - r_credits;

   // ------------------------------------------------------------------------
   // Lane command register
   // ------------------------------------------------------------------------
   logic                  r_wr_cmd_vld;
   logic                  r_rd_cmd_vld;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [ID_WIDTH-1:0]   r_cmd_id;

   // Valid strobes are single-cycle; address/data hold between commands so
   // the lane does not toggle needlessly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cmd_vld <= 1'b0;
         r_rd_cmd_vld <= 1'b0;
         r_addr       <= '0;
         r_wr_data    <= '0;
         r_cmd_id     <= '0;
      end else begin
         r_wr_cmd_vld <= w_acc_wr;
         r_rd_cmd_vld <= w_acc_rd;
         if (w_accept) begin
            r_addr   <= req_addr;
            r_cmd_id <= req_id;
         end
         if (w_acc_wr) begin
            r_wr_data <= req_data;
         end
      end
   end

   assign wr_cmd_vld  = r_wr_cmd_vld;
   assign rd_cmd_vld  = r_rd_cmd_vld;
   assign addr        = r_addr;
   assign wr_cmd_data = r_wr_data;

   // ------------------------------------------------------------------------
   // Latency pipe: tracks {valid, write, id} alongside the lane so that the
   // last stage lines up with the cycle rd_data_in is valid.
   // The pipe is fed from the registered command, so stage 0 is valid one
   // cycle after the command and stage RD_LATENCY-1 exactly RD_LATENCY after.
   // ------------------------------------------------------------------------
   logic                r_pipe_vld [RD_LATENCY];
   logic                r_pipe_wr  [RD_LATENCY];
   logic [ID_WIDTH-1:0] r_pipe_id  [RD_LATENCY];
   logic                w_pipe_in_vld;
   logic                w_pipe_in_wr;

`ifdef SRAM_CHAN_REQ_WR_ACK_EN
   assign w_pipe_in_vld = r_rd_cmd_vld | r_wr_cmd_vld;
   assign w_pipe_in_wr  = r_wr_cmd_vld;
`else
   assign w_pipe_in_vld = r_rd_cmd_vld;
   assign w_pipe_in_wr  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < RD_LATENCY; s++) begin
            r_pipe_vld[s] <= 1'b0;
            r_pipe_wr[s]  <= 1'b0;
            r_pipe_id[s]  <= '0;
         end
      end else begin
         r_pipe_vld[0] <= w_pipe_in_vld;
         r_pipe_wr[0]  <= w_pipe_in_wr;
         r_pipe_id[0]  <= r_cmd_id;
         for (int s = 1; s < RD_LATENCY; s++) begin
            r_pipe_vld[s] <= r_pipe_vld[s-1];
            r_pipe_wr[s]  <= r_pipe_wr[s-1];
            r_pipe_id[s]  <= r_pipe_id[s-1];
         end
      end
   end

   logic [DATA_WIDTH-1:0] w_push_data;
   logic [ID_WIDTH-1:0]   w_push_id;

   assign w_push      = r_pipe_vld[RD_LATENCY-1];
   assign w_push_id   = r_pipe_id[RD_LATENCY-1];
   // Write completions carry no data.
   assign w_push_data = r_pipe_wr[RD_LATENCY-1] ? '0 : rd_data_in;

   // ------------------------------------------------------------------------
   // Response FIFO
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem_data [RSP_DEPTH];
   logic [ID_WIDTH-1:0]   r_mem_id   [RSP_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;

   assign rsp_vld  = (r_count != '0);
   assign w_pop    = rsp_vld & rsp_rdy;
   assign rsp_data = r_mem_data[r_rd_ptr];
   assign rsp_id   = r_mem_id[r_rd_ptr];

   // Storage is cleared on reset so the head reads as zero out of reset.
   // Pointers are PTR_W bits wide and wrap naturally (depth is a power of 2).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < RSP_DEPTH; e++) begin
            r_mem_data[e] <= '0;
            r_mem_id[e]   <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_id[r_wr_ptr]   <= w_push_id;
            r_wr_ptr             <= r_wr_ptr + PTR_ONE_C;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE_C;
         end
         // No bypass: an entry pushed into an empty FIFO shows up next cycle.
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE_C;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_ONE_C;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_chan_req.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_chan_req                                                |
// | Purpose  : Self-checking bench for sram_chan_req. A lane model returns     |
// |            address-derived data RD_LATENCY cycles after each read command; |
// |            expected responses go to a scoreboard queue at accept time and  |
// |            are compared when the DUT hands them out.                       |
// | Option   : honours `define SRAM_CHAN_REQ_WR_ACK_EN for write completions.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sram_chan_req;

   localparam int AW = 11;
   localparam int DW = 32;
   localparam int IW = 4;
   localparam int L  = 2;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          req_vld;
   logic          req_rdy;
   logic          req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_data;
   logic [IW-1:0] req_id;
   logic          wr_cmd_vld;
   logic          rd_cmd_vld;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_cmd_data;
   logic [DW-1:0] rd_data_in;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_data;
   logic [IW-1:0] rsp_id;
   logic [CW-1:0] outstanding;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   sram_chan_req #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .RD_LATENCY (L),
      .RSP_DEPTH  (D)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_id      (req_id),
      .wr_cmd_vld  (wr_cmd_vld),
      .rd_cmd_vld  (rd_cmd_vld),
      .addr        (addr),
      .wr_cmd_data (wr_cmd_data),
      .rd_data_in  (rd_data_in),
      .rsp_vld     (rsp_vld),
      .rsp_rdy     (rsp_rdy),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .outstanding (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane data pattern; address 0x005 returns 0xDEADBEEF.
   function automatic logic [DW-1:0] lane_val(input logic [AW-1:0] a);
      logic [DW-1:0] x;
      x = DW'(a ^ 11'h005);
      return 32'hDEADBEEF ^ (x * 32'h00010001);
   endfunction

   // Lane model: data for a command seen in cycle C is on rd_data_in in C+L.
   logic [DW-1:0] dl [L];
   always @(posedge clk) begin
      dl[0] <= rd_cmd_vld ? lane_val(addr) : 32'hBAD00BAD;
      for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
   end
   assign rd_data_in = dl[L-1];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("cmd_exclusive", 64'(wr_cmd_vld & rd_cmd_vld), 64'd0);
         if (rsp_vld === 1'b1 && rsp_rdy === 1'b1) begin
            total++;
            assert (sb.size() > 0) else begin
               bad++;
               $error("FAIL rsp_unexpected: got id=%0h data=%0h want no response", rsp_id, rsp_data);
            end
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_id_data", 64'({rsp_id, rsp_data}), 64'({e.id, e.data}));
            end
         end
      end
   end

   // Offer a request and hold it until accepted (bounded).
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [IW-1:0] id);
      int n;
      n = 0;
      req_vld  = 1'b1;
      req_wr   = wr;
      req_addr = a;
      req_data = d;
      req_id   = id;
      while (req_rdy !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      total++;
      assert (req_rdy === 1'b1) else begin
         bad++;
         $error("FAIL issue_timeout: req_rdy=%b want 1 (id %0h)", req_rdy, id);
      end
      if (req_rdy === 1'b1) begin
         if (!wr) sb.push_back({id, lane_val(a)});
`ifdef SRAM_CHAN_REQ_WR_ACK_EN
         else sb.push_back({id, 32'd0});
`endif
         step();
      end
   endtask

   // Wait (bounded) until every expected response has been consumed.
   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || outstanding != '0) && n < 60) begin
         step();
         n++;
      end
      repeat (4) step();
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      chk({tag, "_outstanding"}, 64'(outstanding), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nacc;
      rst_n    = 1'b0;
      req_vld  = 1'b0;
      req_wr   = 1'b0;
      req_addr = '0;
      req_data = '0;
      req_id   = '0;
      rsp_rdy  = 1'b0;

      // ---------------- reset state ----------------
      repeat (3) step();
      chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      rst_n = 1'b1;
      step();
      chk("rst_cmd_vld", 64'({wr_cmd_vld, rd_cmd_vld}), 64'd0);
      chk("rst_addr_data", 64'({addr, wr_cmd_data}), 64'd0);
      chk("rst_rsp_payload", 64'({rsp_id, rsp_data}), 64'd0);
      chk("rst_req_rdy", 64'(req_rdy), 64'd1);

      // ---------------- single read, timing ----------------
      issue(1'b0, 11'h005, 32'd0, 4'd3);          // accepted in T, now in T+1
      req_vld = 1'b0;
      chk("rd1_cmd_T1", 64'({rd_cmd_vld, wr_cmd_vld}), 64'b10);
      chk("rd1_addr_T1", 64'(addr), 64'h005);
      step();                                     // T+2
      chk("rd1_cmd_T2", 64'(rd_cmd_vld), 64'd0);
      chk("rd1_addr_hold", 64'(addr), 64'h005);
      step();                                     // T+3
      chk("rd1_rsp_vld_T3", 64'(rsp_vld), 64'd0);
      step();                                     // T+4
      chk("rd1_rsp_vld_T4", 64'(rsp_vld), 64'd1);
      chk("rd1_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
      chk("rd1_rsp_id", 64'(rsp_id), 64'd3);
      chk("rd1_outstanding", 64'(outstanding), 64'd1);
      rsp_rdy = 1'b1;
      step();
      chk("rd1_popped", 64'({rsp_vld, outstanding}), 64'd0);

      // ---------------- write ----------------
      issue(1'b1, 11'h7FF, 32'h12345678, 4'd5);
      req_vld = 1'b0;
      chk("wr_cmd", 64'({wr_cmd_vld, rd_cmd_vld}), 64'b10);
      chk("wr_addr", 64'(addr), 64'h7FF);
      chk("wr_data", 64'(wr_cmd_data), 64'h12345678);
`ifdef SRAM_CHAN_REQ_WR_ACK_EN
      chk("wr_outstanding", 64'(outstanding), 64'd1);
`else
      chk("wr_outstanding", 64'(outstanding), 64'd0);
`endif
      step();
      chk("wr_cmd_off", 64'(wr_cmd_vld), 64'd0);
      chk("wr_addr_hold", 64'({addr, wr_cmd_data}), 64'({11'h7FF, 32'h12345678}));
      drain("wr");

      // ---------------- back-pressure: 6 offered, 4 accepted ----------------
      rsp_rdy = 1'b0;
      nacc    = 0;
      req_vld = 1'b1;
      req_wr  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         req_id   = IW'(nacc);
         req_addr = AW'(11'h100 + nacc);
         if (req_rdy === 1'b1 && nacc < 6) begin
            sb.push_back({req_id, lane_val(req_addr)});
            nacc++;
         end
         step();
      end
      req_vld = 1'b0;
      chk("bp_accepted", 64'(nacc), 64'd4);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      chk("bp_outstanding", 64'(outstanding), 64'd4);
      chk("bp_rsp_vld", 64'(rsp_vld), 64'd1);
      if (sb.size() > 0) chk("bp_head", 64'({rsp_id, rsp_data}), 64'({sb[0].id, sb[0].data}));
      repeat (2) step();
      if (sb.size() > 0) chk("bp_head_stable", 64'({rsp_id, rsp_data}), 64'({sb[0].id, sb[0].data}));
      rsp_rdy = 1'b1;
      drain("bp");
      chk("bp_req_rdy_back", 64'(req_rdy), 64'd1);

      // ---------------- continuous reads, ids 0..15 ----------------
      rsp_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, AW'(11'h200 + i), 32'd0, IW'(i));
      end
      req_vld = 1'b0;
      drain("stream");

      // ---------------- accept + pop at credits = 1 ----------------
      rsp_rdy = 1'b0;
      issue(1'b0, 11'h020, 32'd0, 4'd6);
      issue(1'b0, 11'h021, 32'd0, 4'd7);
      issue(1'b0, 11'h022, 32'd0, 4'd8);
      req_vld = 1'b0;
      repeat (6) step();
      chk("c1_outstanding", 64'(outstanding), 64'd3);
      chk("c1_req_rdy", 64'(req_rdy), 64'd1);
      req_vld  = 1'b1;
      req_wr   = 1'b0;
      req_addr = 11'h030;
      req_id   = 4'd9;
      rsp_rdy  = 1'b1;
      sb.push_back({4'd9, lane_val(11'h030)});
      step();
      req_vld = 1'b0;
      rsp_rdy = 1'b0;
      chk("c1_outstanding_same", 64'(outstanding), 64'd3);
      chk("c1_req_rdy_same", 64'(req_rdy), 64'd1);
      rsp_rdy = 1'b1;
      drain("c1");

      // ---------------- reset with reads in flight ----------------
      rsp_rdy = 1'b0;
      issue(1'b0, 11'h040, 32'd0, 4'd1);
      issue(1'b0, 11'h041, 32'd0, 4'd2);
      req_vld = 1'b0;
      chk("mr_outstanding_pre", 64'(outstanding), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_async_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("mr_async_outstanding", 64'(outstanding), 64'd0);
      chk("mr_async_rd_cmd", 64'(rd_cmd_vld), 64'd0);
      sb.delete();
      repeat (2) step();
      rst_n   = 1'b1;
      rsp_rdy = 1'b1;
      repeat (8) step();
      chk("mr_no_late_push", 64'(rsp_vld), 64'd0);
      chk("mr_outstanding_post", 64'(outstanding), 64'd0);
      chk("mr_req_rdy", 64'(req_rdy), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
